qspi_rom_arbiter: RTL and testbench
===================================

# qspi_rom_arbiter

Shares the single `rom_qspi` read port between the core's instruction-fetch (I) and data (D) requesters. Round-robin arbitration runs over whole ROM transactions. The block sequences the ROM trigger/ready handshake and returns read data to the granted requester. An optional one-word fetch buffer serves repeated instruction fetches from the same word without touching the QSPI flash.

## Interface
Parameters:
- `ADDR_W`, 24: byte address width toward the ROM.
- `BUF_EN`, 1: 1 instantiates the I-side one-word buffer; 0 removes it (every I request goes to the ROM).

Ports:
- `clk`  in  1  single clock; all logic is on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `i_req`  in  1  fetch request; held with `i_addr` until `i_rdy`.
- `i_addr`  in  ADDR_W  fetch byte address; bits [1:0] ignored.
- `i_rdata`  out  32  fetch data, valid while `i_rdy`=1.
- `i_rdy`  out  1  one-cycle completion pulse for I.
- `d_req`  in  1  data read request; held with `d_addr`/`d_sz` until `d_rdy`.
- `d_addr`  in  ADDR_W  data byte address.
- `d_sz`  in  2  0=word, 1=half, 2=byte (3 treated as word).
- `d_rdata`  out  32  data, valid while `d_rdy`=1.
- `d_rdy`  out  1  one-cycle completion pulse for D.
- `inv`  in  1  invalidates the fetch buffer.
- `rom_addr`  out  ADDR_W  to `rom_qspi.baddr`.
- `rom_sz`  out  2  to `rom_qspi.bsz`.
- `rom_trig`  out  1  to `rom_qspi.trigger_rd`.
- `rom_do`  in  32  from `rom_qspi.bdo`.
- `rom_rdy`  in  1  from `rom_qspi.brdy`, one-cycle pulse.
- `busy`  out  1  high when the block is not in the IDLE state.

## Operation
- States: IDLE, ROM (ROM transaction in flight), RESP (completion pulse to a requester).
- IDLE, on each edge:
  - I buffer hit: `BUF_EN`=1, `buf_valid`=1, `i_req`=1, `i_addr[ADDR_W-1:2]`==`buf_tag`. A hit counts as an I grant.
  - If only one requester is eligible, grant it.
  - If both are eligible, grant the one not in `last_grant`. Reset value of `last_grant` is I, so D wins the first tie.
  - I hit: go to RESP with `i_rdata`<=`buf_data`.
  - Any other grant: latch the address and size, then go to ROM.
  - I transactions drive `rom_addr`={`i_addr[ADDR_W-1:2]`,2'b00} and `rom_sz`=0.
  - D transactions drive `d_addr` and `d_sz` unchanged.
- ROM state:
  - `rom_trig`=1; `rom_addr` and `rom_sz` are held constant.
  - On `rom_rdy`=1: capture `rom_do` into the granted `x_rdata`, then go to RESP.
  - If the grant is I and `BUF_EN`=1, also load `buf_tag`, `buf_data`, and set `buf_valid`=1.
- RESP state:
  - `rom_trig`=0; `x_rdy`=1 for the granted requester only; update `last_grant`; go to IDLE.
- `x_rdata` holds its value after the pulse until the next completion for that side.
- `inv`=1 clears `buf_valid` at the edge.
  - If `inv` coincides with a buffer fill, the clear wins and `buf_valid`=0.
  - An I transaction already in flight still completes and returns ROM data.
- D reads never modify the buffer; the ROM is read-only.
- Requests must not be withdrawn before their `x_rdy`. Behaviour is undefined if they are.
- `rom_rdy` arriving outside the ROM state is ignored.

## Timing
- Reset (`rst`=0, asynchronous):
  - All outputs are 0: `rom_trig`, `rom_addr`, `rom_sz`, `i_rdy`, `d_rdy`, `i_rdata`, `d_rdata`, `busy`.
  - State=IDLE, `buf_valid`=0, `last_grant`=I.
  - Mid-transaction reset drops `rom_trig` immediately and discards the pending grant. `rom_qspi` shares the reset.
- ROM path, with the request sampled at edge k:
  - `rom_trig` is high from cycle k+1.
  - With `rom_rdy` sampled at edge m, `x_rdy` and data are valid in cycle m+1, the block is in IDLE in cycle m+2, and a new transaction can start at edge m+2.
- Buffer hit: request sampled at edge k gives `i_rdy` in cycle k+1. Back-to-back hits complete every 2 cycles.
- Between ROM transactions `rom_trig` is low for at least 2 cycles (RESP plus IDLE).
- A requester may present a new address in the cycle after its `x_rdy`. It is sampled at the next IDLE edge.

## Test plan
- Single D read: `d_addr`=0x000003, `d_sz`=0, ROM model returns 0xDEADBEEF after 100 cycles -> `rom_addr`=0x000003, `rom_trig` high until `rom_rdy`; `d_rdy` pulses once with `d_rdata`=0xDEADBEEF; `i_rdy` never pulses.
- Simultaneous `i_req` (0x000100) and `d_req` (0x000200) out of reset -> D is served first, then I. No overlap of `rom_trig`, and at least 2 low cycles between transactions.
- Fairness: hold both requests continuously for 6 transactions -> grants alternate D,I,D,I,D,I.
- Buffer: I fetch 0x000104 (ROM returns 0x12345678), then I fetch 0x000107 -> second `i_rdy` one cycle after its request, `i_rdata`=0x12345678, no `rom_trig`. After `inv`=1, fetch 0x000104 again -> ROM is accessed.
- `BUF_EN`=0: repeat the previous buffer scenario -> every fetch raises `rom_trig`.
- Reset asserted mid-ROM state -> `rom_trig`, `busy`, `x_rdy` go 0 immediately. After release, a fresh D request completes normally and the stale `rom_rdy` is ignored.

Source files
------------

// File: rtl/qspi_rom_arbiter.sv
// Round-robin arbiter sharing one QSPI ROM read port between instruction fetch and data reads,
// with an optional one-word fetch buffer that short-circuits repeated fetches of the same word.
module qspi_rom_arbiter #(
  parameter int ADDR_W = 24,
  parameter int BUF_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [31:0]       i_rdata,
  output logic              i_rdy,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [1:0]        d_sz,
  output logic [31:0]       d_rdata,
  output logic              d_rdy,
  input  logic              inv,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [1:0]        rom_sz,
  output logic              rom_trig,
  input  logic [31:0]       rom_do,
  input  logic              rom_rdy,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ROM, RESP} state_t;

  state_t            state, state_nx;
  logic              gnt_d;
  logic              last_grant;
  logic              grant_i, grant_d;
  logic              hit;
  logic              buf_valid;
  logic [ADDR_W-3:0] buf_tag;
  logic [31:0]       buf_data;
  logic              unused_abits;

  // Fetch byte-lane bits never matter: fetches are always whole words.
  assign unused_abits = &{1'b0, i_addr[1:0]};

  assign hit = (BUF_EN != 0) && buf_valid && i_req && (i_addr[ADDR_W-1:2] == buf_tag);

  always_comb begin
    state_nx = state;
    grant_i  = 1'b0;
    grant_d  = 1'b0;
    case (state)
      IDLE: begin
        if (i_req && d_req) begin
          if (last_grant) grant_i = 1'b1;
          else            grant_d = 1'b1;
        end else if (i_req) begin
          grant_i = 1'b1;
        end else if (d_req) begin
          grant_d = 1'b1;
        end
        if (grant_d)      state_nx = ROM;
        else if (grant_i) state_nx = hit ? RESP : ROM;
      end
      ROM:     if (rom_rdy) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Grant bookkeeping, ROM address latch, read data return and fetch buffer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt_d      <= 1'b0;
      last_grant <= 1'b0;
      rom_addr   <= '0;
      rom_sz     <= '0;
      i_rdata    <= '0;
      d_rdata    <= '0;
      buf_valid  <= 1'b0;
      buf_tag    <= '0;
      buf_data   <= '0;
    end else begin
      if (state == IDLE) begin
        if (grant_d) begin
          gnt_d    <= 1'b1;
          rom_addr <= d_addr;
          rom_sz   <= d_sz;
        end else if (grant_i) begin
          gnt_d <= 1'b0;
          if (hit) begin
            i_rdata <= buf_data;
          end else begin
            rom_addr <= {i_addr[ADDR_W-1:2], 2'b00};
            rom_sz   <= 2'd0;
          end
        end
      end
      if (state == ROM && rom_rdy) begin
        if (gnt_d) begin
          d_rdata <= rom_do;
        end else begin
          i_rdata <= rom_do;
          if (BUF_EN != 0) begin
            buf_tag   <= rom_addr[ADDR_W-1:2];
            buf_data  <= rom_do;
            buf_valid <= 1'b1;
          end
        end
      end
      if (state == RESP) last_grant <= gnt_d;
      // Invalidate takes priority over a fill landing on the same edge.
      if (inv) buf_valid <= 1'b0;
    end
  end

  assign rom_trig = (state == ROM);
  assign i_rdy    = (state == RESP) && !gnt_d;
  assign d_rdy    = (state == RESP) && gnt_d;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_qspi_rom_arbiter.sv
// Directed-vector bench for qspi_rom_arbiter: a small ROM responder, a completion/trigger monitor,
// a vector table for single transactions, and hand sequences for reset, fairness and BUF_EN=0.
module tb_qspi_rom_arbiter;

  typedef struct {
    bit          ireq;
    logic [23:0] iaddr;
    bit          dreq;
    logic [23:0] daddr;
    logic [1:0]  dsz;
    bit          inv;
    int          lat;
    int          exp_trigs;
    bit          exp_first_d;
    logic [31:0] exp_i;
    logic [31:0] exp_d;
    logic [23:0] exp_addr;
    logic [1:0]  exp_sz;
    int          exp_lat;
  } vec_t;

  typedef struct {
    bit          d;
    logic [31:0] data;
  } cpl_t;

  typedef struct {
    logic [23:0] a;
    logic [1:0]  s;
  } st_t;

  logic        clk, rst;
  logic        i_req, d_req, inv;
  logic [23:0] i_addr, d_addr, rom_addr;
  logic [1:0]  d_sz, rom_sz;
  logic [31:0] i_rdata, d_rdata, rom_do;
  logic        i_rdy, d_rdy, rom_trig, rom_rdy, busy;

  logic        nb_i_req, nb_inv, nb_i_rdy, nb_rom_trig, nb_rom_rdy;
  logic [23:0] nb_i_addr, nb_rom_addr;
  logic [31:0] nb_i_rdata, nb_rom_do;
  logic [1:0]  nb_unused_sz;
  logic [31:0] nb_unused_drdata;
  logic        nb_unused_drdy, nb_unused_busy;

  int   checks = 0;
  int   failures = 0;
  int   rom_lat = 2;
  bit   rom_auto = 1;
  bit   force_rdy = 0;
  cpl_t cpl[$];
  st_t  starts[$];
  vec_t vecs[12];

  qspi_rom_arbiter #(.ADDR_W(24), .BUF_EN(1)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_rdy(i_rdy),
    .d_req(d_req), .d_addr(d_addr), .d_sz(d_sz), .d_rdata(d_rdata), .d_rdy(d_rdy),
    .inv(inv),
    .rom_addr(rom_addr), .rom_sz(rom_sz), .rom_trig(rom_trig), .rom_do(rom_do), .rom_rdy(rom_rdy),
    .busy(busy)
  );

  qspi_rom_arbiter #(.ADDR_W(24), .BUF_EN(0)) dut_nb (
    .clk(clk), .rst(rst),
    .i_req(nb_i_req), .i_addr(nb_i_addr), .i_rdata(nb_i_rdata), .i_rdy(nb_i_rdy),
    .d_req(1'b0), .d_addr(24'h0), .d_sz(2'd0), .d_rdata(nb_unused_drdata), .d_rdy(nb_unused_drdy),
    .inv(nb_inv),
    .rom_addr(nb_rom_addr), .rom_sz(nb_unused_sz), .rom_trig(nb_rom_trig), .rom_do(nb_rom_do),
    .rom_rdy(nb_rom_rdy),
    .busy(nb_unused_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom_fn(input logic [23:0] a);
    case (a)
      24'h000003: rom_fn = 32'hDEADBEEF;
      24'h000104: rom_fn = 32'h12345678;
      default:    rom_fn = {8'hA5, a};
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // ROM model: answers rom_lat cycles after trigger, or on demand for a stale pulse.
  initial begin
    int cnt;
    cnt = 0;
    rom_rdy = 1'b0;
    rom_do = '0;
    forever begin
      @(posedge clk); #1;
      if (force_rdy) begin
        rom_rdy = 1'b1;
        rom_do = 32'hBAD0BAD0;
      end else if (rom_auto && rom_trig) begin
        if (cnt >= rom_lat) begin
          rom_rdy = 1'b1;
          rom_do = rom_fn(rom_addr);
          cnt = 0;
        end else begin
          rom_rdy = 1'b0;
          cnt++;
        end
      end else begin
        rom_rdy = 1'b0;
        cnt = 0;
      end
    end
  end

  initial begin
    int cnt;
    cnt = 0;
    nb_rom_rdy = 1'b0;
    nb_rom_do = '0;
    forever begin
      @(posedge clk); #1;
      if (nb_rom_trig) begin
        if (cnt >= 2) begin
          nb_rom_rdy = 1'b1;
          nb_rom_do = rom_fn(nb_rom_addr);
          cnt = 0;
        end else begin
          nb_rom_rdy = 1'b0;
          cnt++;
        end
      end else begin
        nb_rom_rdy = 1'b0;
        cnt = 0;
      end
    end
  end

  // Completion log, trigger starts, low-gap and address-hold checks.
  initial begin
    bit          prev_trig, seen_any;
    int          low_run;
    logic [23:0] st_a;
    logic [1:0]  st_s;
    prev_trig = 0; seen_any = 0; low_run = 2; st_a = '0; st_s = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_trig = 0;
        low_run = 2;
      end else begin
        if (i_rdy || d_rdy) checkOutput("rdy_overlap", {31'd0, i_rdy && d_rdy}, 32'd0);
        if (i_rdy) cpl.push_back('{1'b0, i_rdata});
        if (d_rdy) cpl.push_back('{1'b1, d_rdata});
        if (rom_trig && !prev_trig) begin
          if (seen_any) checkOutput("trig_gap", {31'd0, low_run >= 2}, 32'd1);
          seen_any = 1;
          st_a = rom_addr;
          st_s = rom_sz;
          starts.push_back('{rom_addr, rom_sz});
        end else if (rom_trig) begin
          checkOutput("rom_addr_hold", {6'd0, rom_sz, rom_addr}, {6'd0, st_s, st_a});
        end
        low_run = rom_trig ? 0 : low_run + 1;
        prev_trig = rom_trig;
      end
    end
  end

  task automatic applyStimulus(input vec_t v, output int first_cyc);
    bit i_pend, d_pend;
    int cyc;
    if (v.inv) begin
      @(posedge clk); #1 inv = 1'b1;
      @(posedge clk); #1 inv = 1'b0;
    end
    rom_lat = v.lat;
    cpl.delete();
    starts.delete();
    @(posedge clk); #1;
    i_req = v.ireq; i_addr = v.iaddr;
    d_req = v.dreq; d_addr = v.daddr; d_sz = v.dsz;
    i_pend = v.ireq; d_pend = v.dreq;
    cyc = 0;
    first_cyc = -1;
    while ((i_pend || d_pend) && cyc < 400) begin
      @(posedge clk); cyc++;
      @(negedge clk); #1;
      if (i_pend && i_rdy) begin
        i_pend = 0; i_req = 1'b0;
        if (first_cyc < 0) first_cyc = cyc;
      end
      if (d_pend && d_rdy) begin
        d_pend = 0; d_req = 1'b0;
        if (first_cyc < 0) first_cyc = cyc;
      end
    end
    checkOutput("timeout", {30'd0, i_pend, d_pend}, 32'd0);
    i_req = 1'b0; d_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic checkVector(input string tag, input vec_t v, input int first_cyc);
    int ni, nd;
    logic [31:0] di, dd;
    ni = 0; nd = 0; di = '0; dd = '0;
    foreach (cpl[j]) begin
      if (cpl[j].d) begin nd++; dd = cpl[j].data; end
      else          begin ni++; di = cpl[j].data; end
    end
    checkOutput({tag, "_i_count"}, ni, {31'd0, v.ireq});
    checkOutput({tag, "_d_count"}, nd, {31'd0, v.dreq});
    if (v.ireq) begin
      checkOutput({tag, "_i_data"}, di, v.exp_i);
      checkOutput({tag, "_i_hold"}, i_rdata, v.exp_i);
    end
    if (v.dreq) begin
      checkOutput({tag, "_d_data"}, dd, v.exp_d);
      checkOutput({tag, "_d_hold"}, d_rdata, v.exp_d);
    end
    checkOutput({tag, "_trigs"}, starts.size(), v.exp_trigs);
    if (v.exp_trigs > 0 && starts.size() > 0)
      checkOutput({tag, "_rom_addr_sz"}, {6'd0, starts[0].s, starts[0].a}, {6'd0, v.exp_sz, v.exp_addr});
    if (v.ireq && v.dreq && cpl.size() > 0)
      checkOutput({tag, "_first_d"}, {31'd0, cpl[0].d}, {31'd0, v.exp_first_d});
    if (v.exp_lat >= 0) checkOutput({tag, "_latency"}, first_cyc, v.exp_lat);
  endtask

  task automatic nbFetch(input logic [23:0] a, input logic [31:0] exp);
    bit pend, saw;
    int cyc;
    pend = 1; saw = 0; cyc = 0;
    @(posedge clk); #1 nb_i_req = 1'b1; nb_i_addr = a;
    while (pend && cyc < 50) begin
      @(posedge clk); cyc++;
      @(negedge clk); #1;
      if (nb_rom_trig) saw = 1;
      if (nb_i_rdy) begin
        pend = 0; nb_i_req = 1'b0;
        checkOutput("nb_i_data", nb_i_rdata, exp);
      end
    end
    nb_i_req = 1'b0;
    checkOutput("nb_trig_seen", {31'd0, saw}, 32'd1);
    checkOutput("nb_timeout", {31'd0, pend}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t v;
    int   fc, cyc;

    //           ireq iaddr       dreq daddr       dsz inv lat trg 1stD exp_i         exp_d         addr        sz lat
    vecs[0]  = '{1, 24'h000100, 1, 24'h000200, 2'd0, 0, 2,   2, 1, 32'hA5000100, 32'hA5000200, 24'h000200, 2'd0, -1};
    vecs[1]  = '{0, 24'h000000, 1, 24'h000003, 2'd0, 0, 100, 1, 0, 32'h0,        32'hDEADBEEF, 24'h000003, 2'd0, 102};
    vecs[2]  = '{1, 24'h000104, 0, 24'h000000, 2'd0, 0, 3,   1, 0, 32'h12345678, 32'h0,        24'h000104, 2'd0, 5};
    vecs[3]  = '{1, 24'h000107, 0, 24'h000000, 2'd0, 0, 3,   0, 0, 32'h12345678, 32'h0,        24'h000000, 2'd0, 1};
    vecs[4]  = '{0, 24'h000000, 1, 24'h000104, 2'd2, 0, 1,   1, 0, 32'h0,        32'h12345678, 24'h000104, 2'd2, 3};
    vecs[5]  = '{1, 24'h000104, 0, 24'h000000, 2'd0, 0, 1,   0, 0, 32'h12345678, 32'h0,        24'h000000, 2'd0, 1};
    vecs[6]  = '{1, 24'h000104, 0, 24'h000000, 2'd0, 1, 0,   1, 0, 32'h12345678, 32'h0,        24'h000104, 2'd0, 2};
    vecs[7]  = '{0, 24'h000000, 1, 24'h000010, 2'd3, 0, 2,   1, 0, 32'h0,        32'hA5000010, 24'h000010, 2'd3, 4};
    vecs[8]  = '{0, 24'h000000, 1, 24'h0000FE, 2'd1, 0, 2,   1, 0, 32'h0,        32'hA50000FE, 24'h0000FE, 2'd1, 4};
    vecs[9]  = '{1, 24'h000100, 1, 24'h000300, 2'd0, 0, 2,   2, 0, 32'hA5000100, 32'hA5000300, 24'h000100, 2'd0, -1};
    vecs[10] = '{1, 24'h000102, 0, 24'h000000, 2'd0, 0, 2,   0, 0, 32'hA5000100, 32'h0,        24'h000000, 2'd0, 1};
    vecs[11] = '{1, 24'h00020B, 0, 24'h000000, 2'd0, 0, 2,   1, 0, 32'hA5000208, 32'h0,        24'h000208, 2'd0, 4};

    rst = 1'b0;
    i_req = 0; d_req = 0; inv = 0; i_addr = '0; d_addr = '0; d_sz = '0;
    nb_i_req = 0; nb_inv = 0; nb_i_addr = '0;
    #22;
    checkOutput("rst_rom_trig", {31'd0, rom_trig}, 32'd0);
    checkOutput("rst_rom_addr", {8'd0, rom_addr}, 32'd0);
    checkOutput("rst_rom_sz", {30'd0, rom_sz}, 32'd0);
    checkOutput("rst_i_rdy", {31'd0, i_rdy}, 32'd0);
    checkOutput("rst_d_rdy", {31'd0, d_rdy}, 32'd0);
    checkOutput("rst_i_rdata", i_rdata, 32'd0);
    checkOutput("rst_d_rdata", d_rdata, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk) rst = 1'b1;

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i], fc);
      checkVector($sformatf("v%0d", i), vecs[i], fc);
    end

    // Reset while a ROM transaction is stuck waiting for rom_rdy.
    rom_auto = 0;
    @(posedge clk); #1 d_req = 1'b1; d_addr = 24'h000040; d_sz = 2'd0;
    cyc = 0;
    while (!rom_trig && cyc < 10) begin @(negedge clk); cyc++; end
    checkOutput("midrst_trig_up", {31'd0, rom_trig}, 32'd1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checkOutput("midrst_rom_trig", {31'd0, rom_trig}, 32'd0);
    checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
    checkOutput("midrst_d_rdy", {31'd0, d_rdy}, 32'd0);
    checkOutput("midrst_i_rdy", {31'd0, i_rdy}, 32'd0);
    checkOutput("midrst_rom_addr", {8'd0, rom_addr}, 32'd0);
    checkOutput("midrst_d_rdata", d_rdata, 32'd0);
    d_req = 1'b0;
    rom_auto = 1;
    @(negedge clk) rst = 1'b1; force_rdy = 1;
    @(negedge clk) force_rdy = 0;
    @(negedge clk);
    checkOutput("stale_busy", {31'd0, busy}, 32'd0);
    checkOutput("stale_d_rdy", {31'd0, d_rdy}, 32'd0);
    v = '{0, 24'h000000, 1, 24'h000044, 2'd0, 0, 2, 1, 0, 32'h0, 32'hA5000044, 24'h000044, 2'd0, 4};
    applyStimulus(v, fc);
    checkVector("post_rst_d", v, fc);
    v = '{1, 24'h000104, 0, 24'h000000, 2'd0, 0, 2, 1, 0, 32'h12345678, 32'h0, 24'h000104, 2'd0, 4};
    applyStimulus(v, fc);
    checkVector("post_rst_i_miss", v, fc);

    // Fairness: both requesters held for six transactions right after reset.
    @(negedge clk) rst = 1'b0;
    @(negedge clk) rst = 1'b1;
    cpl.delete();
    rom_lat = 1;
    @(posedge clk); #1;
    i_req = 1'b1; i_addr = 24'h000500;
    d_req = 1'b1; d_addr = 24'h000600; d_sz = 2'd0;
    cyc = 0;
    while (cpl.size() < 6 && cyc < 300) begin @(negedge clk); #1; cyc++; end
    i_req = 1'b0; d_req = 1'b0;
    checkOutput("fair_count", cpl.size(), 32'd6);
    for (int j = 0; j < 6; j++) begin
      if (j < cpl.size()) begin
        checkOutput($sformatf("fair_side%0d", j), {31'd0, cpl[j].d}, {31'd0, (j % 2) == 0});
        checkOutput($sformatf("fair_data%0d", j), cpl[j].data,
                    ((j % 2) == 0) ? 32'hA5000600 : 32'hA5000500);
      end
    end
    repeat (4) @(negedge clk);
    checkOutput("fair_idle", {31'd0, busy}, 32'd0);
    checkOutput("fair_no_extra", cpl.size(), 32'd6);

    // BUF_EN=0 instance: every fetch must reach the ROM, buffer or not.
    nbFetch(24'h000104, 32'h12345678);
    nbFetch(24'h000107, 32'h12345678);
    @(posedge clk); #1 nb_inv = 1'b1;
    @(posedge clk); #1 nb_inv = 1'b0;
    nbFetch(24'h000104, 32'h12345678);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
